// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_pkg;

    localparam int ADC_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sar_state_t;

endpackage

// File: rtl/sar_adc_if.sv
// Analog front-end / sample-consumer bundle of the SAR ADC controller.
// master: the side that requests conversions and supplies the comparator bit.
// slave:  the SAR controller itself.
interface sar_adc_if #(parameter int W = sar_pkg::ADC_WIDTH_DEF);

    logic         cmp;
    logic         start;
    logic [W-1:0] DACF;
    logic         eoc;
    logic         den;
    logic [W-1:0] Dout;

    modport master (
        output cmp,
        output start,
        input  DACF,
        input  eoc,
        input  den,
        input  Dout
    );

    modport slave (
        input  cmp,
        input  start,
        output DACF,
        output eoc,
        output den,
        output Dout
    );

endinterface

// File: rtl/sar_adc.sv
// SAR ADC controller: resolves one bit per clock MSB first, then publishes
// the result with a one-cycle den strobe and a sticky eoc level.
// The code register doubles as the DAC trial code, so DACF is always registered.
module sar_adc
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_adc_if.slave    bus
);

    localparam int IDX_W = (ADC_WIDTH > 1) ? $clog2(ADC_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(ADC_WIDTH - 1);
    localparam logic [ADC_WIDTH-1:0] CODE_MSB = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    sar_state_t           state;
    logic [IDX_W-1:0]     idx;
    logic [ADC_WIDTH-1:0] code_q;
    logic [ADC_WIDTH-1:0] dout_q;
    logic                 eoc_q;
    logic                 den_q;

    logic [ADC_WIDTH-1:0] resolved;
    logic [ADC_WIDTH-1:0] trial;

    // Decide the current bit from the comparator, then raise the next trial bit
    always_comb begin
        resolved = code_q;
        if (!bus.cmp) begin
            resolved[idx] = 1'b0;
        end
        trial = resolved;
        if (idx != '0) begin
            trial[idx - IDX_W'(1)] = 1'b1;
        end
    end

    // Conversion FSM with registered DAC code, result, and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= IDX_MSB;
            code_q <= '0;
            dout_q <= '0;
            eoc_q  <= 1'b0;
            den_q  <= 1'b0;
        end else begin
            den_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        code_q <= CODE_MSB;
                        idx    <= IDX_MSB;
                        eoc_q  <= 1'b0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    // start is deliberately ignored here: no restart, no queueing
                    if (idx != '0) begin
                        code_q <= trial;
                        idx    <= idx - IDX_W'(1);
                    end else begin
                        code_q <= resolved;
                        dout_q <= resolved;
                        den_q  <= 1'b1;
                        eoc_q  <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DACF = code_q;
    assign bus.Dout = dout_q;
    assign bus.eoc  = eoc_q;
    assign bus.den  = den_q;

endmodule

// File: tb/tb_sar_adc.sv
// Self-checking bench for sar_adc (W=8). Stimulus tasks push the expected
// result into a queue; a monitor pops and compares on every den strobe.
module tb_sar_adc;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] vin;

    int errors;
    int checks;
    int exp_q[$];
    logic den_prev;

    sar_adc_if #(.W(W)) bus ();

    sar_adc #(.ADC_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Ideal comparator against the analog input stand-in
    assign bus.cmp = (bus.DACF > vin) ? 1'b0 : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every den strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && bus.den) begin
            if (exp_q.size() == 0) begin
                chk("den_unexpected", 1, 0);
            end else begin
                chk("dout", int'(bus.Dout), exp_q.pop_front());
                chk("eoc_at_den", int'(bus.eoc), 1);
            end
            chk("den_one_cycle", int'(den_prev), 0);
        end
        den_prev = bus.den;
    end

    // One conversion from a start pulse; optional DACF trace and mid-conversion start
    task automatic run_conv(input logic [W-1:0] v, input bit chk_seq, input bit mid_start);
        int seq153 [W];
        int lat;
        seq153 = '{128, 192, 160, 144, 152, 156, 154, 153};
        vin = v;
        exp_q.push_back(int'(v));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        chk("eoc_falls_at_start", int'(bus.eoc), 0);
        if (chk_seq) chk("dacf_0", int'(bus.DACF), seq153[0]);
        while (!bus.den && lat < W + 4) begin
            @(negedge clk);
            lat++;
            bus.start = (mid_start && lat == 4) ? 1'b1 : 1'b0;
            if (chk_seq && lat < W) chk("dacf_trace", int'(bus.DACF), seq153[lat]);
        end
        bus.start = 1'b0;
        chk("latency", lat, W);
        @(negedge clk);
        chk("den_low_after", int'(bus.den), 0);
        chk("eoc_held", int'(bus.eoc), 1);
        chk("dacf_final", int'(bus.DACF), int'(v));
    endtask

    initial begin
        int dens;
        int budget;
        errors    = 0;
        checks    = 0;
        den_prev  = 1'b0;
        rst_n     = 1'b0;
        vin       = '0;
        bus.start = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_dacf", int'(bus.DACF), 0);
        chk("rst_dout", int'(bus.Dout), 0);
        chk("rst_eoc",  int'(bus.eoc), 0);
        chk("rst_den",  int'(bus.den), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // idle with start low holds everything
        repeat (3) @(negedge clk);
        chk("idle_dacf", int'(bus.DACF), 0);

        // single conversion with full DACF trace
        run_conv(8'd153, 1'b1, 1'b0);

        // two starts spaced W+4 clocks apart, same input
        repeat (2) @(negedge clk);
        run_conv(8'd153, 1'b1, 1'b0);

        // boundaries
        run_conv(8'd255, 1'b0, 1'b0);
        run_conv(8'd0,   1'b0, 1'b0);
        run_conv(8'd1,   1'b0, 1'b0);
        run_conv(8'd128, 1'b0, 1'b0);
        run_conv(8'd127, 1'b0, 1'b0);

        // start pulsed mid-conversion is ignored; trace and latency unchanged
        run_conv(8'd153, 1'b1, 1'b1);

        // start held high: conversions back-to-back every W+1 clocks
        vin = 8'd200;
        exp_q.push_back(200);
        exp_q.push_back(200);
        bus.start = 1'b1;
        @(negedge clk);
        dens = 0;
        for (int lat = 1; lat < 2 * (W + 1); lat++) begin
            @(negedge clk);
            if (bus.den) begin
                dens++;
                chk("held_den_pos", lat, (dens == 1) ? W : 2 * W + 1);
            end
        end
        bus.start = 1'b0;
        chk("held_den_count", dens, 2);
        repeat (3) @(negedge clk);

        // reset mid-conversion clears everything including the prior result
        vin = 8'd77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dacf", int'(bus.DACF), 0);
        chk("abort_dout", int'(bus.Dout), 0);
        chk("abort_eoc",  int'(bus.eoc), 0);
        chk("abort_den",  int'(bus.den), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(8'd77, 1'b0, 1'b0);

        // sweep of pseudo-random inputs
        for (int n = 0; n < 100; n++) begin
            run_conv(W'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
